// File: rtl/pipe_seq_ctrl_if.sv
// Sequencer bus between the core datapath and pipe_seq_ctrl.
// The slave side is the sequencer; the master side is the datapath.
interface pipe_seq_ctrl_if #(
    parameter int N_STAGES = 4,
    parameter int REG_AW   = 3,
    parameter int CNT_W    = 16
);
    logic                if_valid;
    logic [REG_AW-1:0]   dc_src_a;
    logic                dc_use_a;
    logic [REG_AW-1:0]   dc_src_b;
    logic                dc_use_b;
    logic [REG_AW-1:0]   dc_dst;
    logic                dc_wr;
    logic                jump_taken;
    logic                mem_busy;
    logic [N_STAGES-1:0] ld_stage;
    logic [N_STAGES-1:0] stage_valid;
    logic                hazard;
    logic                stall;
    logic                flush;
    logic                retire;
    logic [REG_AW-1:0]   retire_dst;
    logic                retire_wr;
    logic [CNT_W-1:0]    stall_cnt;

    modport master (
        output if_valid, dc_src_a, dc_use_a, dc_src_b, dc_use_b,
        output dc_dst, dc_wr, jump_taken, mem_busy,
        input  ld_stage, stage_valid, hazard, stall, flush,
        input  retire, retire_dst, retire_wr, stall_cnt
    );

    modport slave (
        input  if_valid, dc_src_a, dc_use_a, dc_src_b, dc_use_b,
        input  dc_dst, dc_wr, jump_taken, mem_busy,
        output ld_stage, stage_valid, hazard, stall, flush,
        output retire, retire_dst, retire_wr, stall_cnt
    );
endinterface

// File: rtl/pipe_seq_ctrl.sv
// N-stage pipeline sequencer: per-stage valid/dst tracking, RAW stall,
// jump flush, memory hold and a saturating stall-cycle counter.
module pipe_seq_ctrl #(
    parameter int N_STAGES   = 4,
    parameter int JUMP_STAGE = 2,
    parameter int REG_AW     = 3,
    parameter int CNT_W      = 16
) (
    input logic            clk,
    input logic            reset,
    pipe_seq_ctrl_if.slave bus
);
    localparam int L = N_STAGES - 1;

    if (N_STAGES < 4) begin : g_bad_n
        $error("pipe_seq_ctrl: N_STAGES must be >= 4");
    end
    if (JUMP_STAGE < 2 || JUMP_STAGE > N_STAGES - 2) begin : g_bad_j
        $error("pipe_seq_ctrl: JUMP_STAGE out of range");
    end

    logic [L:1]        valid_q, valid_d;
    logic [L:1]        wr_q, wr_d;
    logic [REG_AW-1:0] dst_q [1:L];
    logic [REG_AW-1:0] dst_d [1:L];
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic                hold, flush, hazard, stall;
    logic                match_a, match_b;
    logic [N_STAGES-1:0] ld;

    always_comb begin
        match_a = 1'b0;
        match_b = 1'b0;
        // Retiring writers still match: no write-through assumed.
        for (int k = 2; k <= L; k++) begin
            if (valid_q[k] && wr_q[k] && dst_q[k] == bus.dc_src_a)
                match_a = 1'b1;
            if (valid_q[k] && wr_q[k] && dst_q[k] == bus.dc_src_b)
                match_b = 1'b1;
        end
        hold   = valid_q[L] & bus.mem_busy;
        hazard = valid_q[1] & ((bus.dc_use_a & match_a) |
                               (bus.dc_use_b & match_b));
        flush  = bus.jump_taken & valid_q[JUMP_STAGE] & ~hold;
        stall  = hazard & ~flush & ~hold;
    end

    always_comb begin
        valid_d     = valid_q;
        wr_d        = wr_q;
        dst_d       = dst_q;
        stall_cnt_d = stall_cnt_q;
        ld          = '1;
        unique case (1'b1)
            hold: begin
                ld = '0;
            end
            flush: begin
                valid_d[1] = bus.if_valid;
                wr_d[1]    = bus.dc_wr;
                dst_d[1]   = bus.dc_dst;
                for (int k = 2; k <= L; k++) begin
                    valid_d[k] = valid_q[k-1];
                    wr_d[k]    = wr_q[k-1];
                    dst_d[k]   = dst_q[k-1];
                end
                for (int k = 1; k <= JUMP_STAGE; k++)
                    valid_d[k] = 1'b0;
            end
            stall: begin
                ld[1:0] = 2'b00;
                for (int k = 2; k <= L; k++) begin
                    valid_d[k] = valid_q[k-1];
                    wr_d[k]    = wr_q[k-1];
                    dst_d[k]   = dst_q[k-1];
                end
                valid_d[2] = 1'b0;
            end
            default: begin
                valid_d[1] = bus.if_valid;
                wr_d[1]    = bus.dc_wr;
                dst_d[1]   = bus.dc_dst;
                for (int k = 2; k <= L; k++) begin
                    valid_d[k] = valid_q[k-1];
                    wr_d[k]    = wr_q[k-1];
                    dst_d[k]   = dst_q[k-1];
                end
            end
        endcase
        if ((stall || hold) && stall_cnt_q != {CNT_W{1'b1}})
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= '0;
            wr_q        <= '0;
            stall_cnt_q <= '0;
            for (int k = 1; k <= L; k++)
                dst_q[k] <= '0;
        end else begin
            valid_q     <= valid_d;
            wr_q        <= wr_d;
            stall_cnt_q <= stall_cnt_d;
            for (int k = 1; k <= L; k++)
                dst_q[k] <= dst_d[k];
        end
    end

    // State is already cleared in reset; only the load strobes need gating.
    assign bus.ld_stage    = reset ? ld : '0;
    assign bus.stage_valid = {valid_q, bus.if_valid};
    assign bus.hazard      = hazard;
    assign bus.stall       = stall;
    assign bus.flush       = flush;
    assign bus.retire      = valid_q[L] & ~bus.mem_busy;
    assign bus.retire_dst  = dst_q[L];
    assign bus.retire_wr   = wr_q[L] & valid_q[L] & ~bus.mem_busy;
    assign bus.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Randomized + directed bench for pipe_seq_ctrl against an
// instruction-slot reference model (N_STAGES=4, JUMP_STAGE=2).
module tb_pipe_seq_ctrl;
    localparam int NS = 4;
    localparam int AW = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_seq_ctrl_if #(.N_STAGES(NS), .REG_AW(AW), .CNT_W(16)) bus ();
    pipe_seq_ctrl_if #(.N_STAGES(NS), .REG_AW(AW), .CNT_W(4))  bus4 ();

    assign bus4.if_valid   = bus.if_valid;
    assign bus4.dc_src_a   = bus.dc_src_a;
    assign bus4.dc_use_a   = bus.dc_use_a;
    assign bus4.dc_src_b   = bus.dc_src_b;
    assign bus4.dc_use_b   = bus.dc_use_b;
    assign bus4.dc_dst     = bus.dc_dst;
    assign bus4.dc_wr      = bus.dc_wr;
    assign bus4.jump_taken = bus.jump_taken;
    assign bus4.mem_busy   = bus.mem_busy;

    pipe_seq_ctrl #(.N_STAGES(NS), .JUMP_STAGE(2), .REG_AW(AW), .CNT_W(16))
        dut (.clk(clk), .reset(rst_n), .bus(bus));
    pipe_seq_ctrl #(.N_STAGES(NS), .JUMP_STAGE(2), .REG_AW(AW), .CNT_W(4))
        dut4 (.clk(clk), .reset(rst_n), .bus(bus4));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Instruction slots for stages 1..3; cnt_ref is the unsaturated count.
    typedef struct { bit v; bit [2:0] dst; bit wr; } slot_t;
    slot_t pipe [1:3];
    longint cnt_ref;
    bit m_hold, m_stall, m_flush;

    function automatic bit pending(input bit [2:0] r);
        for (int k = 2; k <= 3; k++)
            if (pipe[k].v && pipe[k].wr && pipe[k].dst == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic longint sat(input longint c, input longint mx);
        return (c > mx) ? mx : c;
    endfunction

    task automatic model_reset();
        for (int k = 1; k <= 3; k++) pipe[k] = '{1'b0, 3'd0, 1'b0};
        cnt_ref = 0;
    endtask

    task automatic check_outputs();
        bit hz, rt;
        logic [3:0] exp_ld;
        m_hold  = pipe[3].v && bus.mem_busy;
        hz      = pipe[1].v &&
                  ((bus.dc_use_a && pending(bus.dc_src_a)) ||
                   (bus.dc_use_b && pending(bus.dc_src_b)));
        m_flush = bus.jump_taken && pipe[2].v && !m_hold;
        m_stall = hz && !m_flush && !m_hold;
        rt      = pipe[3].v && !bus.mem_busy;
        exp_ld  = m_hold ? 4'b0000 : (m_stall ? 4'b1100 : 4'b1111);
        chk("ld_stage", bus.ld_stage, exp_ld);
        chk("stage_valid", bus.stage_valid,
            {pipe[3].v, pipe[2].v, pipe[1].v, bus.if_valid});
        chk("hazard", bus.hazard, hz);
        chk("stall", bus.stall, m_stall);
        chk("flush", bus.flush, m_flush);
        chk("retire", bus.retire, rt);
        chk("retire_wr", bus.retire_wr, pipe[3].wr && rt);
        if (rt) chk("retire_dst", bus.retire_dst, pipe[3].dst);
        chk("stall_cnt", bus.stall_cnt, 32'(sat(cnt_ref, 65535)));
        chk("stall_cnt4", bus4.stall_cnt, 32'(sat(cnt_ref, 15)));
    endtask

    task automatic model_step();
        if (m_hold) begin
        end else if (m_stall) begin
            pipe[3]   = pipe[2];
            pipe[2].v = 1'b0;
        end else begin
            pipe[3] = pipe[2];
            pipe[2] = pipe[1];
            pipe[1] = '{bus.if_valid, bus.dc_dst, bus.dc_wr};
            if (m_flush) begin
                pipe[1].v = 1'b0;
                pipe[2].v = 1'b0;
            end
        end
        if (m_hold || m_stall) cnt_ref++;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit iv, input bit [2:0] d, input bit w,
                         input bit ua, input bit [2:0] sa,
                         input bit ub, input bit [2:0] sb,
                         input bit j, input bit mb);
        bus.if_valid   = iv;
        bus.dc_dst     = d;
        bus.dc_wr      = w;
        bus.dc_use_a   = ua;
        bus.dc_src_a   = sa;
        bus.dc_use_b   = ub;
        bus.dc_src_b   = sb;
        bus.jump_taken = j;
        bus.mem_busy   = mb;
    endtask

    initial begin
        model_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("rst_ld", bus.ld_stage, 4'b0000);
        chk("rst_sv", bus.stage_valid, 4'b0001);
        chk("rst_retire", bus.retire, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fill the pipe, then reset asynchronously mid-cycle.
        drive(1, 3'd1, 1, 0, 0, 0, 0, 0, 0);
        repeat (3) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sv", bus.stage_valid, 4'b0001);
        chk("mid_rst_ld", bus.ld_stage, 4'b0000);
        chk("mid_rst_cnt", bus.stall_cnt, 0);
        chk("mid_rst_retire_wr", bus.retire_wr, 1'b0);
        chk("mid_rst_retire_dst", bus.retire_dst, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) cycle();

        // RAW on r3 through source A: two stall cycles then clear.
        drive(1, 3'd3, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(1, 3'd6, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 3'd0, 0, 1, 3'd3, 0, 0, 0, 0);
        cycle();
        chk("raw_bubble", bus.stage_valid[2], 1'b0);
        repeat (3) cycle();
        chk("raw_cnt", bus.stall_cnt, 2);

        // Jump resolving at stage 2 while decode hazards on r5.
        drive(1, 3'd5, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(1, 3'd2, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(1, 3'd4, 0, 0, 0, 1, 3'd5, 1, 0);
        cycle();
        chk("jmp_sv", bus.stage_valid[3:1], 3'b100);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) cycle();
        chk("jmp_cnt", bus.stall_cnt, 2);

        // Memory hold for 3 cycles with a jump pending.
        drive(1, 3'd7, 1, 0, 0, 0, 0, 0, 0);
        repeat (3) cycle();
        drive(1, 3'd1, 1, 0, 0, 0, 0, 1, 1);
        repeat (3) cycle();
        drive(1, 3'd1, 1, 0, 0, 0, 0, 0, 0);
        chk("hold_cnt", bus.stall_cnt, 5);
        cycle();

        // Long hold saturates the narrow counter.
        drive(0, 3'd2, 1, 0, 0, 0, 0, 0, 1);
        repeat (20) cycle();
        chk("sat4", bus4.stall_cnt, 4'hF);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) cycle();

        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 99) < 80, 3'($urandom),
                  $urandom_range(0, 99) < 70,
                  $urandom_range(0, 99) < 60, 3'($urandom),
                  $urandom_range(0, 99) < 40, 3'($urandom),
                  $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 20);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end
endmodule
